an_sec_decoder_pipe: RTL and testbench

//  - Pipelined, parametrised single-error-correcting AN-code decoder with valid/ready streaming.
//  - Input W = A*N + e, where e is 0 or a single arithmetic-weight error +/-2^i.
//  - Output is the recovered N plus corrected/uncorrectable status.
//  - Sits between the AN-coded arithmetic datapath and the plain-binary consumer.

---
 rtl/an_sec_pkg.sv | 66 ++++++
 rtl/an_sec_decoder_pipe_syndrome_lut.sv | 42 ++++
 rtl/an_sec_decoder_pipe.sv | 190 +++++++++++++++++++
 tb/tb_an_sec_decoder_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/an_sec_pkg.sv
// Shared definitions for the AN-code single-error-correcting decoder:
// default code parameters, the power-of-two residue helper used to build
// the syndrome table, and the syndrome lookup result type.
package an_sec_pkg;

    localparam int AN_A      = 1939;
    localparam int AN_N_BITS = 8;
    localparam int AN_W_BITS = 19;
    localparam int AN_R_BITS = 11;

    // Delta is carried at a fixed generous width in the struct so the type
    // does not depend on module parameters; W_BITS up to 30 fits.
    localparam int AN_DELTA_BITS = 32;

    typedef struct packed {
        logic signed [AN_DELTA_BITS-1:0] delta;
        logic                            corr;
        logic                            uncorr;
    } syn_res_t;

    // 2^i mod a, computed by repeated doubling so no wide intermediate is needed.
    function automatic int unsigned pow2_mod(input int unsigned i, input int unsigned a);
        int unsigned r;
        r = 32'd1 % a;
        for (int unsigned k = 32'd0; k < i; k++) begin
            r = (r * 32'd2) % a;
        end
        return r;
    endfunction

    // Residue of syndrome entry k: entries 0..w-1 are +2^k, entries w..2w-1 are -2^(k-w).
    function automatic int unsigned syn_entry(input int unsigned k, input int unsigned a,
                                              input int unsigned w);
        int unsigned r;
        if (k < w) begin
            r = pow2_mod(k, a);
        end else begin
            r = a - pow2_mod(k - w, a);
        end
        return r;
    endfunction

    // True when all 2*w syndromes are nonzero, below a and pairwise distinct.
    function automatic bit syn_table_ok(input int unsigned a, input int unsigned w);
        bit          ok;
        int unsigned ri;
        ok = 1'b1;
        for (int unsigned i = 32'd0; i < 32'd2 * w; i++) begin
            ri = syn_entry(i, a, w);
            if ((ri == 32'd0) || (ri >= a)) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
            for (int unsigned j = i + 32'd1; j < 32'd2 * w; j++) begin
                if (ri == syn_entry(j, a, w)) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/an_sec_decoder_pipe_syndrome_lut.sv
// Combinational syndrome lookup: residue R -> {Delta, corr, uncorr}.
// The table of +/-2^i residues is generated from A and W_BITS at elaboration;
// because every syndrome is unique, at most one hit bit is ever set, so the
// hit vectors read as numbers are directly the magnitude 2^i.
module an_sec_syndrome_lut
    import an_sec_pkg::*;
#(
    parameter int A      = AN_A,
    parameter int W_BITS = AN_W_BITS,
    parameter int R_BITS = AN_R_BITS
) (
    input  logic [R_BITS-1:0] r_i,
    output syn_res_t          res_o
);

    logic [W_BITS-1:0] pos_hit_s;
    logic [W_BITS-1:0] neg_hit_s;
    logic              corr_s;

    if (!syn_table_ok(A, W_BITS)) begin : g_bad_table
        $error("an_sec_syndrome_lut: syndrome residues not unique/nonzero/below A");
    end

    for (genvar i = 0; i < W_BITS; i++) begin : g_tab
        localparam int unsigned     POS   = pow2_mod(i, A);
        localparam logic [R_BITS-1:0] POS_R = R_BITS'(POS);
        localparam logic [R_BITS-1:0] NEG_R = R_BITS'(A - POS);
        assign pos_hit_s[i] = (r_i == POS_R);
        assign neg_hit_s[i] = (r_i == NEG_R);
    end

    // Fold the one-hot hits into a signed correction and the status flags.
    always_comb begin
        corr_s       = (|pos_hit_s) | (|neg_hit_s);
        res_o        = '0;
        res_o.delta  = $signed({{(AN_DELTA_BITS-W_BITS){1'b0}}, pos_hit_s})
                     - $signed({{(AN_DELTA_BITS-W_BITS){1'b0}}, neg_hit_s});
        res_o.corr   = corr_s;
        res_o.uncorr = (r_i != '0) & ~corr_s;
    end

endmodule

// File: rtl/an_sec_decoder_pipe.sv
// Three-stage pipelined single-error-correcting AN-code decoder with
// valid/ready streaming on both sides.
//   S1: residue R = W mod A
//   S2: syndrome lookup -> signed correction Delta and flags
//   S3: C = W - Delta, range check, N = C / A (output register)
// Optional build macro AN_SEC_ERR_CNT_EN adds saturating 16-bit counters of
// corrected and uncorrectable output transfers with a synchronous clear.
module an_sec_decoder_pipe
    import an_sec_pkg::*;
#(
    parameter int N_BITS = AN_N_BITS,
    parameter int A      = AN_A,
    parameter int W_BITS = AN_W_BITS,
    parameter int R_BITS = AN_R_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_BITS-1:0] in_w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_n,
    output logic              out_corr,
    output logic              out_uncorr
`ifdef AN_SEC_ERR_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [15:0]       cnt_corr,
    output logic [15:0]       cnt_uncorr
`endif
);

    // C needs one extra bit over W for the sign and one for W + 2^(W_BITS-1).
    localparam int             CW    = W_BITS + 2;
    localparam logic [CW-1:0]  C_MAX = CW'(A * ((2 ** N_BITS) - 1));
    localparam logic [CW-1:0]  A_CW  = CW'(A);

    logic                     s1_valid_q;
    logic [W_BITS-1:0]        s1_w_q;
    logic [R_BITS-1:0]        s1_r_q;

    logic                     s2_valid_q;
    logic [W_BITS-1:0]        s2_w_q;
    logic signed [W_BITS:0]   s2_delta_q;
    logic                     s2_corr_q;
    logic                     s2_uncorr_q;

    logic                     out_valid_q;
    logic [N_BITS-1:0]        out_n_q;
    logic                     out_corr_q;
    logic                     out_uncorr_q;

    logic                     out_adv_s;
    logic                     s2_en_s;
    logic                     s1_en_s;
    logic [R_BITS-1:0]        r_s;
    syn_res_t                 lut_res_s;
    logic                     unused_delta_s;
    logic signed [CW-1:0]     c_s;
    logic [CW-1:0]            quot_s;
    logic                     in_range_s;
    logic [N_BITS-1:0]        out_n_d;
    logic                     out_corr_d;
    logic                     out_uncorr_d;

    // Each stage may load when the stage after it is empty or moving on.
    always_comb begin
        out_adv_s = !out_valid_q || out_ready;
        s2_en_s   = !s2_valid_q || out_adv_s;
        s1_en_s   = !s1_valid_q || s2_en_s;
    end

    assign in_ready = s1_en_s;
    assign r_s      = R_BITS'(in_w % W_BITS'(A));

    // S1: capture codeword and its residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_w_q     <= '0;
            s1_r_q     <= '0;
        end else if (s1_en_s) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_w_q <= in_w;
                s1_r_q <= r_s;
            end
        end
    end

    an_sec_syndrome_lut #(
        .A      (A),
        .W_BITS (W_BITS),
        .R_BITS (R_BITS)
    ) u_lut (
        .r_i   (s1_r_q),
        .res_o (lut_res_s)
    );

    // Only the low W_BITS+1 bits of the generic-width delta are meaningful.
    assign unused_delta_s = ^lut_res_s.delta[AN_DELTA_BITS-1:W_BITS+1];

    // S2: capture the correction and syndrome flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_w_q      <= '0;
            s2_delta_q  <= '0;
            s2_corr_q   <= 1'b0;
            s2_uncorr_q <= 1'b0;
        end else if (s2_en_s) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_w_q      <= s1_w_q;
                s2_delta_q  <= lut_res_s.delta[W_BITS:0];
                s2_corr_q   <= lut_res_s.corr;
                s2_uncorr_q <= lut_res_s.uncorr;
            end
        end
    end

    // S3 datapath: apply correction, range-check, divide by A.
    always_comb begin
        c_s        = $signed({2'b00, s2_w_q}) - $signed({s2_delta_q[W_BITS], s2_delta_q});
        in_range_s = !c_s[CW-1] && ($unsigned(c_s) <= C_MAX);
        quot_s     = $unsigned(c_s) / A_CW;
        if (s2_uncorr_q || !in_range_s) begin
            out_n_d      = '0;
            out_corr_d   = 1'b0;
            out_uncorr_d = 1'b1;
        end else begin
            out_n_d      = N_BITS'(quot_s);
            out_corr_d   = s2_corr_q;
            out_uncorr_d = 1'b0;
        end
    end

    // S3: output register; holds its contents while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_n_q      <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
        end else if (out_adv_s) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_n_q      <= out_n_d;
                out_corr_q   <= out_corr_d;
                out_uncorr_q <= out_uncorr_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_n      = out_n_q;
    assign out_corr   = out_corr_q;
    assign out_uncorr = out_uncorr_q;

`ifdef AN_SEC_ERR_CNT_EN
    logic        out_xfer_s;
    logic [15:0] cnt_corr_q;
    logic [15:0] cnt_uncorr_q;

    assign out_xfer_s = out_valid_q && out_ready;

    // Saturating error counters; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corr_q   <= 16'd0;
            cnt_uncorr_q <= 16'd0;
        end else if (cnt_clr) begin
            cnt_corr_q   <= 16'd0;
            cnt_uncorr_q <= 16'd0;
        end else begin
            if (out_xfer_s && out_corr_q && (cnt_corr_q != 16'hFFFF)) begin
                cnt_corr_q <= cnt_corr_q + 16'd1;
            end
            if (out_xfer_s && out_uncorr_q && (cnt_uncorr_q != 16'hFFFF)) begin
                cnt_uncorr_q <= cnt_uncorr_q + 16'd1;
            end
        end
    end

    assign cnt_corr   = cnt_corr_q;
    assign cnt_uncorr = cnt_uncorr_q;
`endif

endmodule

// File: tb/tb_an_sec_decoder_pipe.sv
// Scoreboard bench for an_sec_decoder_pipe (A=1939, N_BITS=8, W_BITS=19).
// The driver pushes the hand-computed expectation of each codeword when it is
// accepted; an independent monitor pops and compares on every output transfer.
module tb_an_sec_decoder_pipe;

    localparam int A      = 1939;
    localparam int N_BITS = 8;
    localparam int W_BITS = 19;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [W_BITS-1:0] in_w      = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [N_BITS-1:0] out_n;
    logic              out_corr;
    logic              out_uncorr;
`ifdef AN_SEC_ERR_CNT_EN
    logic              cnt_clr   = 1'b0;
    logic [15:0]       cnt_corr;
    logic [15:0]       cnt_uncorr;
`endif

    an_sec_decoder_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_w       (in_w),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_n      (out_n),
        .out_corr   (out_corr),
        .out_uncorr (out_uncorr)
`ifdef AN_SEC_ERR_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  n;
        logic        corr;
        logic        uncorr;
        logic        lat;
        logic [1:0]  bp;
        logic [31:0] cyc;
    } exp_t;

    typedef struct {
        logic [W_BITS-1:0] w;
        logic [7:0]        n;
        logic              corr;
        logic              uncorr;
    } vec_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;

    logic [7:0] exp_n      = 8'd0;
    logic       exp_corr   = 1'b0;
    logic       exp_uncorr = 1'b0;
    logic       exp_lat    = 1'b0;
    logic [1:0] exp_bp     = 2'd0;

    vec_t vecs [10] = '{
        '{19'd9759,   8'd5,   1'b1, 1'b0},   // +2^6
        '{19'd7647,   8'd5,   1'b1, 1'b0},   // -2^11
        '{19'd3,      8'd0,   1'b0, 1'b1},   // no syndrome match
        '{19'd1938,   8'd1,   1'b1, 1'b0},   // -1 -> C = A
        '{19'd494446, 8'd255, 1'b1, 1'b0},   // +1 -> C = 255*A (top of range)
        '{19'd496384, 8'd0,   1'b0, 1'b1},   // 256*A, clean but above range
        '{19'd109,    8'd0,   1'b0, 1'b1},   // +2^11 -> C negative
        '{19'd64,     8'd0,   1'b1, 1'b0},   // +2^6 -> C = 0
        '{19'd226668, 8'd100, 1'b1, 1'b0},   // 100*A + 2^15
        '{19'd125656, 8'd200, 1'b1, 1'b0}    // 200*A - 2^18
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic send(input logic [W_BITS-1:0] w, input logic [7:0] n, input logic c,
                        input logic u, input logic lat, input logic [1:0] bp);
        logic got;
        @(posedge clk); #1;
        in_valid   = 1'b1;
        in_w       = w;
        exp_n      = n;
        exp_corr   = c;
        exp_uncorr = u;
        exp_lat    = lat;
        exp_bp     = bp;
        got        = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept w=%0d", w);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (sb.size() != 0 || out_valid); k++) begin
            @(negedge clk);
        end
        @(negedge clk); #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: one pass per negedge, compares transfers that the next posedge completes.
    initial begin : monitor
        exp_t       e;
        logic       hold_prev;
        logic [7:0] prev_n;
        logic       prev_c;
        logic       prev_u;
        int         bp_last;
        hold_prev = 1'b0;
        prev_n    = 8'd0;
        prev_c    = 1'b0;
        prev_u    = 1'b0;
        bp_last   = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_valid",  32'(out_valid),  32'd1);
                    chk("hold_n",      32'(out_n),      32'(prev_n));
                    chk("hold_corr",   32'(out_corr),   32'(prev_c));
                    chk("hold_uncorr", 32'(out_uncorr), 32'(prev_u));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out actual=n%0d required=no_output", out_n);
                    end else begin
                        e = sb.pop_front();
                        chk("out_n",      32'(out_n),      32'(e.n));
                        chk("out_corr",   32'(out_corr),   32'(e.corr));
                        chk("out_uncorr", 32'(out_uncorr), 32'(e.uncorr));
                        if (e.lat) begin
                            chk("latency", 32'(cyc) - e.cyc, 32'd3);
                        end
                        if (e.bp == 2'd2) begin
                            chk("bp_no_gap", 32'(cyc - bp_last), 32'd1);
                        end
                        if (e.bp != 2'd0) begin
                            bp_last = cyc;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back('{n: exp_n, corr: exp_corr, uncorr: exp_uncorr,
                                   lat: exp_lat, bp: exp_bp, cyc: 32'(cyc)});
                    acc_cnt++;
                end
                hold_prev = out_valid && !out_ready;
                prev_n    = out_n;
                prev_c    = out_corr;
                prev_u    = out_uncorr;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int base;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_n",      32'(out_n),      32'd0);
        chk("rst_out_corr",   32'(out_corr),   32'd0);
        chk("rst_out_uncorr", 32'(out_uncorr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Clean codeword with latency check on an empty pipe.
        send(19'd9695, 8'd5, 1'b0, 1'b0, 1'b1, 2'd0);
        idle();
        drain();

        // Directed vectors back to back.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].w, vecs[i].n, vecs[i].corr, vecs[i].uncorr, 1'b0, 2'd0);
        end
        idle();
        drain();

        // Backpressure: six clean codewords while the consumer stalls.
        @(posedge clk); #1;
        out_ready = 1'b0;
        base      = acc_cnt;
        fork
            begin
                for (int n = 1; n <= 6; n++) begin
                    send(W_BITS'(n * A), 8'(n), 1'b0, 1'b0, 1'b0, (n == 1) ? 2'd1 : 2'd2);
                end
                idle();
            end
            begin
                repeat (5) @(negedge clk);
                #1;
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_held_count",   32'(acc_cnt - base), 32'd3);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two codewords in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(W_BITS'(2 * A), 8'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        send(W_BITS'(3 * A), 8'd3, 1'b0, 1'b0, 1'b0, 2'd0);
        idle();
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(W_BITS'(A), 8'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        idle();
        drain();

`ifdef AN_SEC_ERR_CNT_EN
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("cnt_corr_cleared",   32'(cnt_corr),   32'd0);
        chk("cnt_uncorr_cleared", 32'(cnt_uncorr), 32'd0);
        send(19'd9759, 8'd5, 1'b1, 1'b0, 1'b0, 2'd0);
        send(19'd7647, 8'd5, 1'b1, 1'b0, 1'b0, 2'd0);
        send(19'd3,    8'd0, 1'b0, 1'b1, 1'b0, 2'd0);
        send(19'd1938, 8'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        idle();
        drain();
        chk("cnt_corr",   32'(cnt_corr),   32'd3);
        chk("cnt_uncorr", 32'(cnt_uncorr), 32'd1);
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("cnt_corr_clr",   32'(cnt_corr),   32'd0);
        chk("cnt_uncorr_clr", 32'(cnt_uncorr), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
